// File: rtl/vco_adc_capture_ctrl.sv
// vco_adc_capture_ctrl: one VCO-ADC burst - enable, settle, capture quantizer bits LSB-first into words,
// buffer the words in a FWFT FIFO drained over valid/ready.
module vco_adc_capture_ctrl #(
    parameter int SETTLE_CYCLES = 64,
    parameter int WORD_W        = 32,
    parameter int FIFO_DEPTH    = 8,
    parameter int CNT_W         = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_i,
    input  logic                          abort_i,
    input  logic [CNT_W-1:0]              num_words_i,
    input  logic                          q_in_i,
    output logic                          vco_en_n_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          overflow_o,
    output logic [WORD_W-1:0]             m_data_o,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);
    localparam int SC_W = $clog2(SETTLE_CYCLES + 1);
    localparam int BC_W = $clog2(WORD_W + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int LW   = PW + 1;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

    state_t            state_q, state_d;
    logic [1:0]        sync_q;
    logic [SC_W-1:0]   sc_q, sc_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic [CNT_W-1:0]  wc_q, wc_d, nw_q, nw_d;
    logic [WORD_W-1:0] sh_q, sh_d, word;
    logic              vco_en_n_q, busy_q, done_q, ovf_q, ovf_d;
    logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wp_q, rp_q;
    logic [LW-1:0]     lvl_q;
    logic              accept, push, pop, full, wr, run_d;

    assign accept = state_q == IDLE && start_i && !abort_i;
    assign word   = {sync_q[1], sh_q[WORD_W-1:1]};
    assign full   = lvl_q == LW'(FIFO_DEPTH);
    assign pop    = lvl_q != '0 && m_ready_i;
    assign wr     = push && (!full || pop);
    assign run_d  = state_d == SETTLE || state_d == CAPTURE;

    always_comb begin
        state_d = state_q;
        sc_d    = sc_q;
        bc_d    = bc_q;
        wc_d    = wc_q;
        nw_d    = nw_q;
        sh_d    = sh_q;
        ovf_d   = ovf_q;
        push    = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                nw_d    = num_words_i;
                ovf_d   = 1'b0;
                sc_d    = '0;
                bc_d    = '0;
                wc_d    = '0;
                sh_d    = '0;
                state_d = num_words_i == '0 ? DONE : SETTLE;
            end
            SETTLE: begin
                sc_d    = sc_q + SC_W'(1);
                state_d = abort_i ? IDLE : sc_q == SC_W'(SETTLE_CYCLES - 1) ? CAPTURE : SETTLE;
            end
            CAPTURE: if (abort_i) begin
                state_d = IDLE;
                bc_d    = '0;
                sh_d    = '0;
            end else begin
                sh_d = word;
                bc_d = bc_q + BC_W'(1);
                if (bc_q == BC_W'(WORD_W - 1)) begin
                    // words count as produced even when the FIFO drops them
                    push    = 1'b1;
                    bc_d    = '0;
                    wc_d    = wc_q + CNT_W'(1);
                    state_d = wc_q + CNT_W'(1) == nw_q ? DONE : CAPTURE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (push && full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sync_q     <= '0;
            sc_q       <= '0;
            bc_q       <= '0;
            wc_q       <= '0;
            nw_q       <= '0;
            sh_q       <= '0;
            vco_en_n_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            wp_q       <= '0;
            rp_q       <= '0;
            lvl_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[0], q_in_i};
            sc_q       <= sc_d;
            bc_q       <= bc_d;
            wc_q       <= wc_d;
            nw_q       <= nw_d;
            sh_q       <= sh_d;
            // enable lags busy by one cycle on entry, drops together with it on exit
            vco_en_n_q <= !(busy_q && run_d);
            busy_q     <= run_d;
            done_q     <= state_d == DONE;
            ovf_q      <= ovf_d;
            if (wr) mem_q[wp_q] <= word;
            wp_q       <= wp_q + PW'(wr);
            rp_q       <= rp_q + PW'(pop);
            lvl_q      <= lvl_q + LW'(wr) - LW'(pop);
        end
    end

    assign vco_en_n_o   = vco_en_n_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign overflow_o   = ovf_q;
    assign m_data_o     = mem_q[rp_q];
    assign m_valid_o    = lvl_q != '0;
    assign fifo_level_o = lvl_q;
endmodule

// File: tb/tb_vco_adc_capture_ctrl.sv
// tb_vco_adc_capture_ctrl: directed burst scenarios with random quantizer/ready traffic,
// compared every cycle against a timing-rule reference model.
module tb_vco_adc_capture_ctrl;
    localparam int S = 4, W = 32, D = 8, CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1, start = 1'b0, abort = 1'b0, q_in = 1'b0, m_ready = 1'b0;
    logic [CW-1:0] num_words = '0;
    logic          vco_en_n, busy, done, overflow, m_valid;
    logic [W-1:0]  m_data;
    logic [3:0]    fifo_level;

    vco_adc_capture_ctrl #(.SETTLE_CYCLES(S), .WORD_W(W), .FIFO_DEPTH(D), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start_i(start), .abort_i(abort), .num_words_i(num_words),
        .q_in_i(q_in), .vco_en_n_o(vco_en_n), .busy_o(busy), .done_o(done),
        .overflow_o(overflow), .m_data_o(m_data), .m_valid_o(m_valid), .m_ready_i(m_ready),
        .fifo_level_o(fifo_level)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0;
    bit hist [0:19999];
    bit act = 0, dn = 0, ovf_m = 0, vco_m = 1, alt = 0, rr = 0;
    int a_edge = 0, nw_m = 0, lvl_keep;
    logic [W-1:0] fq[$];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: drive q_in/m_ready, advance the model by the burst timing rules, compare all outputs
    task automatic tick();
        int c;
        logic [W-1:0] wd;
        q_in = alt ? bit'((cyc + 1 - (a_edge + S - 1)) % 2 == 0) : 1'($urandom);
        if (rr) m_ready = 1'($urandom);
        @(posedge clk);
        cyc++;
        hist[cyc] = rst ? 1'b0 : q_in;
        if (rst) begin
            fq.delete();
            act = 0; dn = 0; ovf_m = 0; vco_m = 1;
        end else begin
            if (fq.size() > 0 && m_ready) void'(fq.pop_front());
            if (dn) dn = 0;
            else if (act) begin
                if (abort) begin
                    act = 0; vco_m = 1;
                end else begin
                    vco_m = 0;
                    c = cyc - a_edge - S;
                    if (c >= 1 && c % W == 0) begin
                        wd = '0;
                        for (int j = 0; j < W; j++) wd[j] = hist[a_edge + S + 1 + (c - W) + j - 2];
                        if (fq.size() < D) fq.push_back(wd); else ovf_m = 1;
                        if (c == W * nw_m) begin
                            act = 0; dn = 1; vco_m = 1;
                        end
                    end
                end
            end else if (start && !abort) begin
                ovf_m = 0; a_edge = cyc; nw_m = int'(num_words);
                if (num_words == 0) dn = 1; else act = 1;
            end
        end
        #1;
        chk("busy", busy, act);
        chk("vco_en_n", vco_en_n, vco_m);
        chk("done", done, dn);
        chk("overflow", overflow, ovf_m);
        chk("m_valid", m_valid, fq.size() > 0);
        chk("level", fifo_level, fq.size());
        if (fq.size() > 0) chk("m_data", m_data, fq[0]);
    endtask

    task automatic go(int n);
        num_words = CW'(n);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_until_done(int budget, string tag);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        chk(tag, done, 1);
    endtask

    initial begin
        // reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_mdata", m_data, 0);
        chk("rst_vco", vco_en_n, 1);
        tick();

        // alternating pattern, two words held in the FIFO
        alt = 1;
        go(2);
        run_until_done(200, "pattern_done");
        alt = 0;
        tick();
        chk("pattern_w0", m_data, 32'h5555_5555);
        m_ready = 1'b1;
        tick();
        chk("pattern_w1", m_data, 32'h5555_5555);
        tick();
        m_ready = 1'b0;
        chk("pattern_empty", fifo_level, 0);

        // overflow: 10 words into 8 entries with no consumer
        go(10);
        run_until_done(500, "ovf_done");
        chk("ovf_level", fifo_level, 8);
        chk("ovf_flag", overflow, 1);
        tick();

        // full FIFO, pop coincides with the completing push
        go(1);
        chk("ovf_cleared", overflow, 0);
        while (cyc < a_edge + S + W - 1) tick();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("fullpop_level", fifo_level, 8);
        chk("fullpop_ovf", overflow, 0);
        chk("fullpop_done", done, 1);
        m_ready = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        m_ready = 1'b0;
        chk("drained", fifo_level, 0);

        // abort ten cycles into capture
        go(3);
        while (cyc < a_edge + S + 9) tick();
        lvl_keep = int'(fifo_level);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_vco", vco_en_n, 1);
        for (int i = 0; i < 40; i++) tick();
        chk("abort_nopush", fifo_level, lvl_keep);

        // corners: zero-length burst, start while busy, start with abort
        go(0);
        chk("zero_done", done, 1);
        chk("zero_vco", vco_en_n, 1);
        tick();
        chk("zero_done_end", done, 0);
        go(1);
        tick();
        tick();
        go(5);
        run_until_done(100, "busy_start_done");
        chk("busy_start_words", fifo_level, 1);
        abort = 1'b1;
        go(2);
        abort = 1'b0;
        chk("startabort_idle", busy, 0);
        tick();

        // randomized bursts with random consumer back-pressure
        rr = 1;
        for (int b = 0; b < 6; b++) begin
            go(int'($urandom_range(0, 3)));
            run_until_done(200, "rand_done");
            tick();
        end
        rr = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 10; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
